// File: rtl/adj_pkg.sv
// Shared types and constants for the adjustment-filter sequencer.
package adj_pkg;

    localparam int LEVEL_W       = 4;
    localparam int LEVEL_RST     = 8;
    localparam int HOLD_FRAMES   = 30;
    localparam int REPEAT_FRAMES = 4;

    function automatic int cnt_width(input int hold, input int rep);
        return $clog2((hold > rep) ? hold : rep) + 1;
    endfunction

    localparam int FRAME_CNT_W = cnt_width(HOLD_FRAMES, REPEAT_FRAMES);

    typedef enum logic [1:0] {
        KEY_IDLE,
        KEY_ARMED,
        KEY_HOLD,
        KEY_REPEAT
    } key_state_t;

endpackage

// File: rtl/adj_sequencer_key_repeat.sv
// Per-direction key handler: edge detect, press-and-hold auto-repeat, pending step flag.
//
// state      | meaning
// KEY_IDLE   | key released, waiting for a rising edge
// KEY_ARMED  | first step pending, waiting for its frame strobe
// KEY_HOLD   | first step issued, counting frames until auto-repeat
// KEY_REPEAT | auto-repeat, one step every REPEAT_FRAMES frames
module key_repeat #(
    parameter int HOLD_FRAMES   = 30,
    parameter int REPEAT_FRAMES = 4,
    parameter int CNT_W         = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    input  logic frame_en,
    input  logic clear,
    input  logic block,
    output logic pending,
    output logic busy
);
    import adj_pkg::*;

    // Intervals are measured issue-to-issue; pending is raised one frame before its issue.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_FRAMES);

    key_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             key_q, rise, set_pend, pend_nxt;

    assign rise    = key & ~key_q;
    assign cnt_inc = cnt + 1'b1;
    assign busy    = (state != KEY_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= KEY_IDLE;
            cnt     <= '0;
            key_q   <= 1'b0;
            pending <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            key_q   <= key;
            pending <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        set_pend  = 1'b0;
        case (state)
            KEY_IDLE: begin
                if (rise && !block) begin
                    state_nxt = KEY_ARMED;
                    set_pend  = 1'b1;
                end
            end
            KEY_ARMED: begin
                if (frame_en) begin
                    state_nxt = KEY_HOLD;
                    cnt_nxt   = '0;
                end
            end
            KEY_HOLD: begin
                if (frame_en) begin
                    if (cnt_inc == HOLD_LAST) begin
                        state_nxt = KEY_REPEAT;
                        cnt_nxt   = '0;
                        set_pend  = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            KEY_REPEAT: begin
                if (frame_en) begin
                    if (cnt_inc == REP_LAST) begin
                        cnt_nxt  = '0;
                        set_pend = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            default: state_nxt = KEY_IDLE;
        endcase

        if (!key || clear) begin
            state_nxt = KEY_IDLE;
            cnt_nxt   = '0;
            set_pend  = 1'b0;
        end

        // A step already pending survives a release and is consumed by its frame strobe.
        if (clear)
            pend_nxt = 1'b0;
        else
            pend_nxt = set_pend | (pending & ~frame_en);
    end

endmodule

// File: rtl/adj_sequencer.sv
// Frame-synchronous key sequencer for the per-pixel adjustment filters:
// frame strobe, filter enables, inc/dec routing, selection and shadow levels.
module adj_sequencer #(
    parameter int NUM_FILT      = 4,
    parameter int SEL_W         = 2,
    parameter int LEVEL_W       = adj_pkg::LEVEL_W,
    parameter int LEVEL_RST     = adj_pkg::LEVEL_RST,
    parameter int HOLD_FRAMES   = adj_pkg::HOLD_FRAMES,
    parameter int REPEAT_FRAMES = adj_pkg::REPEAT_FRAMES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vs_in,
    input  logic                key_up,
    input  logic                key_dn,
    input  logic                key_sel,
    input  logic [NUM_FILT-1:0] en_sw,
    output logic                frame_en,
    output logic [NUM_FILT-1:0] filt_en,
    output logic [NUM_FILT-1:0] inc,
    output logic [NUM_FILT-1:0] dec,
    output logic [SEL_W-1:0]    sel,
    output logic [LEVEL_W-1:0]  level_sel
);
    import adj_pkg::*;

    localparam int CNT_W = cnt_width(HOLD_FRAMES, REPEAT_FRAMES);

    logic               vs_q, sel_q, lock;
    logic               conflict, block, sel_rise, sel_ok;
    logic               pend_up, pend_dn, busy_up, busy_dn, step_up, step_dn;
    logic [SEL_W-1:0]   sel_nxt;
    logic [LEVEL_W-1:0] shadow     [NUM_FILT];
    logic [LEVEL_W-1:0] shadow_nxt [NUM_FILT];

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q     <= 1'b0;
            frame_en <= 1'b0;
            filt_en  <= '0;
        end else begin
            vs_q     <= vs_in;
            frame_en <= vs_in & ~vs_q;
            if (frame_en)
                filt_en <= en_sw;
        end
    end

    // After both keys were seen together, neither side re-arms until both are released.
    assign conflict = key_up & key_dn;
    assign block    = conflict | lock;

    always_ff @(posedge clk) begin
        if (rst)
            lock <= 1'b0;
        else if (conflict)
            lock <= 1'b1;
        else if (!key_up && !key_dn)
            lock <= 1'b0;
    end

    key_repeat #(
        .HOLD_FRAMES  (HOLD_FRAMES),
        .REPEAT_FRAMES(REPEAT_FRAMES),
        .CNT_W        (CNT_W)
    ) u_key_up (
        .clk     (clk),
        .rst     (rst),
        .key     (key_up),
        .frame_en(frame_en),
        .clear   (conflict),
        .block   (block),
        .pending (pend_up),
        .busy    (busy_up)
    );

    key_repeat #(
        .HOLD_FRAMES  (HOLD_FRAMES),
        .REPEAT_FRAMES(REPEAT_FRAMES),
        .CNT_W        (CNT_W)
    ) u_key_dn (
        .clk     (clk),
        .rst     (rst),
        .key     (key_dn),
        .frame_en(frame_en),
        .clear   (conflict),
        .block   (block),
        .pending (pend_dn),
        .busy    (busy_dn)
    );

    assign step_up = frame_en & pend_up & ~conflict;
    assign step_dn = frame_en & pend_dn & ~conflict;

    always_comb begin
        inc      = '0;
        dec      = '0;
        inc[sel] = step_up;
        dec[sel] = step_dn;
    end

    assign sel_rise = key_sel & ~sel_q;
    assign sel_ok   = ~(busy_up | busy_dn | pend_up | pend_dn);
    // NUM_FILT is a power of two, so the increment wraps to 0 on its own.
    assign sel_nxt  = (sel_rise && sel_ok) ? sel + 1'b1 : sel;

    always_comb begin
        shadow_nxt = shadow;
        if (filt_en[sel]) begin
            if (step_up && !step_dn && shadow[sel] != '1)
                shadow_nxt[sel] = shadow[sel] + 1'b1;
            else if (step_dn && !step_up && shadow[sel] != '0)
                shadow_nxt[sel] = shadow[sel] - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_FILT; i++)
                shadow[i] <= LEVEL_W'(LEVEL_RST);
            sel       <= '0;
            sel_q     <= 1'b0;
            level_sel <= LEVEL_W'(LEVEL_RST);
        end else begin
            shadow    <= shadow_nxt;
            sel       <= sel_nxt;
            sel_q     <= key_sel;
            level_sel <= shadow_nxt[sel_nxt];
        end
    end

endmodule

// File: tb/tb_adj_sequencer.sv
// Directed self-checking bench for adj_sequencer: inputs driven and outputs sampled on the falling edge.
module tb_adj_sequencer;

    logic       clk = 1'b0;
    logic       rst, vs_in, key_up, key_dn, key_sel;
    logic [3:0] en_sw, filt_en, inc, dec;
    logic       frame_en;
    logic [1:0] sel;
    logic [3:0] level_sel;

    int checks = 0;
    int errors = 0;

    logic       fe_obs, fe_post;
    logic [3:0] inc_obs, dec_obs, fen_obs, inc_post, lvl_post;
    int         fe_cnt, fe_first, exp_dec, lvl;
    logic [3:0] strobe_or, fen_at_fe, fen_after;

    always #5 clk = ~clk;

    adj_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .vs_in    (vs_in),
        .key_up   (key_up),
        .key_dn   (key_dn),
        .key_sel  (key_sel),
        .en_sw    (en_sw),
        .frame_en (frame_en),
        .filt_en  (filt_en),
        .inc      (inc),
        .dec      (dec),
        .sel      (sel),
        .level_sel(level_sel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One short frame: vs_in high 2 cycles, low 4; captures the strobe cycle and the cycle after.
    task automatic run_frame();
        vs_in = 1'b1;
        @(negedge clk);
        fe_obs  = frame_en;
        inc_obs = inc;
        dec_obs = dec;
        fen_obs = filt_en;
        @(negedge clk);
        fe_post  = frame_en;
        inc_post = inc;
        lvl_post = level_sel;
        vs_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_key_up();
        key_up = 1'b1;
        repeat (2) @(negedge clk);
        key_up = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_key_sel();
        key_sel = 1'b1;
        @(negedge clk);
        key_sel = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; vs_in = 1'b0; key_up = 1'b0; key_dn = 1'b0; key_sel = 1'b0; en_sw = 4'b0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_frame_en", 32'(frame_en), 0);
        chk("rst_filt_en", 32'(filt_en), 0);
        chk("rst_inc", 32'(inc), 0);
        chk("rst_dec", 32'(dec), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_level", 32'(level_sel), 8);

        // Long VSYNC: exactly one strobe, on the cycle after vs_in is first high.
        en_sw = 4'b0001;
        vs_in = 1'b1;
        fe_cnt = 0; fe_first = -1; strobe_or = 4'b0000; fen_at_fe = 4'hf; fen_after = 4'hf;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (frame_en) begin
                fe_cnt++;
                if (fe_first < 0) fe_first = i;
            end
            strobe_or = strobe_or | inc | dec;
            if (i == 1) fen_at_fe = filt_en;
            if (i == 2) fen_after = filt_en;
        end
        vs_in = 1'b0;
        @(negedge clk);
        chk("vs_fe_count", 32'(fe_cnt), 1);
        chk("vs_fe_cycle", 32'(fe_first), 1);
        chk("vs_no_strobe", 32'(strobe_or), 0);
        chk("vs_level", 32'(level_sel), 8);
        chk("filt_en_during_fe", 32'(fen_at_fe), 0);
        chk("filt_en_after_fe", 32'(fen_after), 1);

        // Single press between frames.
        pulse_key_up();
        run_frame();
        chk("single_fe", 32'(fe_obs), 1);
        chk("single_inc", 32'(inc_obs), 1);
        chk("single_dec", 32'(dec_obs), 0);
        chk("single_inc_post", 32'(inc_post), 0);
        chk("single_fe_post", 32'(fe_post), 0);
        chk("single_level", 32'(lvl_post), 9);

        // Hold key_dn: steps at frames 1, 31, 35, 39, ... clamping at 0.
        key_dn = 1'b1;
        @(negedge clk);
        lvl = 9;
        for (int f = 1; f <= 64; f++) begin
            run_frame();
            exp_dec = (f == 1 || (f >= 31 && (f - 31) % 4 == 0)) ? 1 : 0;
            if (exp_dec != 0 && lvl != 0) lvl--;
            chk("hold_dec", 32'(dec_obs), exp_dec);
            chk("hold_level", 32'(lvl_post), lvl);
            if (f == 10) begin
                pulse_key_sel();
                chk("sel_during_hold", 32'(sel), 0);
            end
        end
        key_dn = 1'b0;
        @(negedge clk);
        run_frame();
        chk("release_dec", 32'(dec_obs), 0);
        chk("release_level", 32'(lvl_post), 0);

        // Both keys rising together: no step.
        key_up = 1'b1; key_dn = 1'b1;
        repeat (2) @(negedge clk);
        key_up = 1'b0; key_dn = 1'b0;
        @(negedge clk);
        run_frame();
        chk("conflict_inc", 32'(inc_obs), 0);
        chk("conflict_dec", 32'(dec_obs), 0);

        // Up re-pressed before both keys were ever low together: still locked out.
        key_up = 1'b1; key_dn = 1'b1;
        @(negedge clk);
        key_up = 1'b0;
        @(negedge clk);
        key_up = 1'b1; key_dn = 1'b0;
        @(negedge clk);
        key_up = 1'b0;
        @(negedge clk);
        run_frame();
        chk("lock_inc", 32'(inc_obs), 0);
        chk("lock_dec", 32'(dec_obs), 0);

        pulse_key_up();
        run_frame();
        chk("after_conflict_inc", 32'(inc_obs), 1);
        chk("after_conflict_level", 32'(lvl_post), 1);

        // Selection wraps 1, 2, 3, 0.
        for (int k = 1; k <= 4; k++) begin
            pulse_key_sel();
            chk("sel_step", 32'(sel), k % 4);
            chk("sel_level", 32'(level_sel), (k % 4 == 0) ? 1 : 8);
        end
        pulse_key_sel();
        pulse_key_sel();
        chk("sel_two", 32'(sel), 2);

        // Disabled filter: strobe routed but shadow frozen.
        pulse_key_up();
        run_frame();
        chk("dis_filt_en", 32'(fen_obs), 1);
        chk("dis_inc", 32'(inc_obs), 4);
        chk("dis_dec", 32'(dec_obs), 0);
        chk("dis_level", 32'(lvl_post), 8);

        en_sw = 4'b0101;
        run_frame();
        chk("en_reload", 32'(filt_en), 5);
        pulse_key_up();
        run_frame();
        chk("en_inc", 32'(inc_obs), 4);
        chk("en_level", 32'(lvl_post), 9);

        // Reset with a step pending discards it.
        pulse_key_up();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_sel", 32'(sel), 0);
        chk("rst2_level", 32'(level_sel), 8);
        chk("rst2_filt_en", 32'(filt_en), 0);
        run_frame();
        chk("rst2_fe", 32'(fe_obs), 1);
        chk("rst2_inc", 32'(inc_obs), 0);
        chk("rst2_frame_level", 32'(lvl_post), 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
